store_writer: RTL and testbench

Write-side sequencer for the row/column latch storage arrays (store_2x2 and larger variants), where each column's latches are transparent while that column's capture line is high.
- Accepts one full array word through a valid/ready handshake.
- Walks the columns in order: drives the row data lines, then pulses one column capture line per column.
- Guarantees setup and hold around every capture pulse, so the latches never see data change while their enable is high.

---
 rtl/store_pkg.sv | 35 +++
 rtl/store_phase_timer.sv | 34 +++
 rtl/store_writer.sv | 171 +++++++++++++++++
 tb/tb_store_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the row/column latch store sequencers.
// Holds the write FSM state encoding, the row/column to word-bit index
// mapping, the default phase timings shared by writers and readers, and a
// width helper for the phase timer.
package store_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Default phase lengths in clock cycles; every one of them must be >= 1.
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_CAP_CYC   = 1;
  localparam int DEF_HOLD_CYC  = 1;

  // Word bit that holds the latch at row r, column c. This matches the
  // array's out index.
  function automatic int bit_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // Counter width needed to hold the largest load value, which is
  // max(phase)-1. The result is never narrower than one bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/store_phase_timer.sv
// Loadable down-counter that times one FSM phase.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - load load_val this cycle; takes priority over counting
//   load_val  - cycles remaining minus one for the phase being entered
//   expired   - count has reached zero; the current phase ends at this edge
module store_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments only. Every flop
  // then samples values from before the edge, whatever order the
  // simulator evaluates the blocks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/store_writer.sv
// Write-side sequencer for row/column latch storage arrays.
// It accepts one array word, then handles each column in turn. For a
// column it drives the row data lines, waits SETUP_CYC cycles, pulses that
// column's capture line for CAP_CYC cycles, and holds the data for
// HOLD_CYC cycles. Data never changes while any capture line is high.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   in_valid  - a write word is presented
//   in_ready  - the writer accepts a word this cycle (IDLE only)
//   in_data   - word to store; bit r*COLS+c is row r, column c
//   dat       - row data lines to the array
//   cap       - column capture lines, at most one high
//   busy      - a write sequence is in progress
//   done      - one-cycle pulse after the last column has been held
module store_writer
  import store_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int CAP_CYC   = DEF_CAP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*COLS-1:0] in_data,
  output logic [ROWS-1:0]      dat,
  output logic [COLS-1:0]      cap,
  output logic                 busy,
  output logic                 done
);

  localparam int TW = timer_width(SETUP_CYC, CAP_CYC, HOLD_CYC);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] CAP_LOAD   = TW'(CAP_CYC - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYC - 1);

  state_e                state;
  logic [CW-1:0]         col;
  logic [CW-1:0]         next_col;
  logic                  last_col;
  logic [ROWS*COLS-1:0]  shadow;
  logic                  accept;
  logic                  timer_load;
  logic [TW-1:0]         timer_val;
  logic                  expired;
  logic [COLS-1:0]       onehot;

  // The word rearranged by column, so each column's row bits come out as
  // one vector. in_col0 lets dat be driven on the same edge that accepts
  // the word, before the shadow register holds it.
  logic [ROWS-1:0] col_word [COLS];
  logic [ROWS-1:0] in_col0;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign col_word[c][r] = shadow[bit_idx(r, c, COLS)];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_in_col0
    assign in_col0[r] = in_data[bit_idx(r, 0, COLS)];
  end

  assign accept   = in_valid && in_ready;
  assign next_col = col + CW'(1);
  assign last_col = (col == CW'(COLS - 1));

  // NOTE: every variable assigned in always_comb gets a default value
  // first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    onehot      = '0;
    onehot[col] = 1'b1;
  end

  // The timer is loaded on the same edge that enters a timed phase. That
  // makes expired valid in the first cycle of the phase.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state)
      IDLE: if (accept) begin
        timer_load = 1'b1;
        timer_val  = SETUP_LOAD;
      end
      SETUP: if (expired) begin
        timer_load = 1'b1;
        timer_val  = CAP_LOAD;
      end
      CAPTURE: if (expired) begin
        timer_load = 1'b1;
        timer_val  = HOLD_LOAD;
      end
      HOLD: if (expired && !last_col) begin
        timer_load = 1'b1;
        timer_val  = SETUP_LOAD;
      end
      default: ;
    endcase
  end

  store_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (expired)
  );

  // NOTE: shadow is pure datapath and is only read after a word has been
  // loaded into it, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      dat      <= '0;
      cap      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            col      <= '0;
            dat      <= in_col0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= SETUP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SETUP: if (expired) begin
          cap   <= onehot;
          state <= CAPTURE;
        end
        CAPTURE: if (expired) begin
          cap   <= '0;
          state <= HOLD;
        end
        HOLD: if (expired) begin
          if (last_col) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            // cap has been low since HOLD was entered, so dat can change.
            col   <= next_col;
            dat   <= col_word[next_col];
            state <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_writer.sv
// Testbench for store_writer. Three instances are used: A has the default
// 2x2 timing, B is a 2x2 array with timing 2/3/2, and C is a 3x4 array.
// A latch-array model sits behind each instance. The bench pushes accepted
// words to a queue and pops them when done pulses.
module tb_store_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2x2, default timing.
  logic v_a = 1'b0, rdy_a, busy_a, done_a;
  logic [3:0] d_a = '0;
  logic [1:0] dat_a, cap_a;
  // Instance B: 2x2, setup 2, capture 3, hold 2.
  logic v_b = 1'b0, rdy_b, busy_b, done_b;
  logic [3:0] d_b = '0;
  logic [1:0] dat_b, cap_b;
  // Instance C: 3 rows by 4 columns, default timing.
  logic v_c = 1'b0, rdy_c, busy_c, done_c;
  logic [11:0] d_c = '0;
  logic [2:0] dat_c;
  logic [3:0] cap_c;

  store_writer #(.ROWS(2), .COLS(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(rdy_a), .in_data(d_a),
    .dat(dat_a), .cap(cap_a), .busy(busy_a), .done(done_a));

  store_writer #(.ROWS(2), .COLS(2), .SETUP_CYC(2), .CAP_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(v_b), .in_ready(rdy_b), .in_data(d_b),
    .dat(dat_b), .cap(cap_b), .busy(busy_b), .done(done_b));

  store_writer #(.ROWS(3), .COLS(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(v_c), .in_ready(rdy_c), .in_data(d_c),
    .dat(dat_c), .cap(cap_c), .busy(busy_c), .done(done_c));

  // Latch models, expected-word queues and the previous-cycle values.
  logic [3:0]  lat_a, lat_b;
  logic [11:0] lat_c;
  logic [3:0]  q_a[$], q_b[$];
  logic [11:0] q_c[$];
  logic [1:0] pdat_a, pcap_a, pdat_b, pcap_b;
  logic [2:0] pdat_c;
  logic [3:0] pcap_c;
  logic rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= rst;

  // Row bits of column c of word w, as the array's latches see them.
  function automatic logic [2:0] col_bits(input logic [11:0] w, input int c,
                                          input int rows, input int cols);
    logic [2:0] o;
    o = '0;
    for (int r = 0; r < rows; r++) o[r] = w[r * cols + c];
    return o;
  endfunction

  // Monitors check properties on every cycle, update the latch models and
  // run the scoreboard.
  always @(negedge clk) begin
    logic [3:0] e;
    checks++;
    if (!$onehot0(cap_a)) begin errors++; $display("FAIL onehot_a cap=%b", cap_a); end
    if (!rst_seen) begin
      checks++;
      if ((cap_a != 0 || pcap_a != 0) && dat_a !== pdat_a) begin
        errors++; $display("FAIL dat_stable_a dat=%b prev=%b cap=%b", dat_a, pdat_a, cap_a);
      end
    end
    for (int c = 0; c < 2; c++)
      if (cap_a[c]) for (int r = 0; r < 2; r++) lat_a[r*2+c] = dat_a[r];
    if (v_a && rdy_a) q_a.push_back(d_a);
    if (done_a) begin
      checks++;
      if (q_a.size() == 0) begin errors++; $display("FAIL sb_a done with no word pending"); end
      else begin
        e = q_a.pop_front();
        if (lat_a !== e) begin errors++; $display("FAIL sb_a array=%b want=%b", lat_a, e); end
      end
    end
    pdat_a = dat_a; pcap_a = cap_a;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    checks++;
    if (!$onehot0(cap_b)) begin errors++; $display("FAIL onehot_b cap=%b", cap_b); end
    if (!rst_seen) begin
      checks++;
      if ((cap_b != 0 || pcap_b != 0) && dat_b !== pdat_b) begin
        errors++; $display("FAIL dat_stable_b dat=%b prev=%b cap=%b", dat_b, pdat_b, cap_b);
      end
    end
    for (int c = 0; c < 2; c++)
      if (cap_b[c]) for (int r = 0; r < 2; r++) lat_b[r*2+c] = dat_b[r];
    if (v_b && rdy_b) q_b.push_back(d_b);
    if (done_b) begin
      checks++;
      if (q_b.size() == 0) begin errors++; $display("FAIL sb_b done with no word pending"); end
      else begin
        e = q_b.pop_front();
        if (lat_b !== e) begin errors++; $display("FAIL sb_b array=%b want=%b", lat_b, e); end
      end
    end
    pdat_b = dat_b; pcap_b = cap_b;
  end

  always @(negedge clk) begin
    logic [11:0] e;
    checks++;
    if (!$onehot0(cap_c)) begin errors++; $display("FAIL onehot_c cap=%b", cap_c); end
    if (!rst_seen) begin
      checks++;
      if ((cap_c != 0 || pcap_c != 0) && dat_c !== pdat_c) begin
        errors++; $display("FAIL dat_stable_c dat=%b prev=%b cap=%b", dat_c, pdat_c, cap_c);
      end
    end
    for (int c = 0; c < 4; c++)
      if (cap_c[c]) for (int r = 0; r < 3; r++) lat_c[r*4+c] = dat_c[r];
    if (v_c && rdy_c) q_c.push_back(d_c);
    if (done_c) begin
      checks++;
      if (q_c.size() == 0) begin errors++; $display("FAIL sb_c done with no word pending"); end
      else begin
        e = q_c.pop_front();
        if (lat_c !== e) begin errors++; $display("FAIL sb_c array=%h want=%h", lat_c, e); end
      end
    end
    pdat_c = dat_c; pcap_c = cap_c;
  end

  // Each wait returns at the negedge of the cycle in which done is high.
  task automatic wait_done_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin @(negedge clk); if (done_a) ok = 1'b1; end
  endtask

  task automatic wait_done_c(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin @(negedge clk); if (done_c) ok = 1'b1; end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, dat_a, cap_a, busy_a, done_a} !== 7'b0) begin
      errors++; $display("FAIL reset_a got rdy=%b dat=%b cap=%b busy=%b done=%b want all 0",
                         rdy_a, dat_a, cap_a, busy_a, done_a);
    end
    checks++;
    if ({rdy_b, busy_b, done_b, cap_b} !== 5'b0 || {rdy_c, busy_c, done_c, cap_c, dat_c} !== 10'b0) begin
      errors++; $display("FAIL reset_bc got rdy_b=%b rdy_c=%b cap_c=%b dat_c=%b want 0",
                         rdy_b, rdy_c, cap_c, dat_c);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (!(rdy_a === 1'b1 && rdy_b === 1'b1 && rdy_c === 1'b1)) begin
      errors++; $display("FAIL reset_release rdy=%b%b%b want 111", rdy_a, rdy_b, rdy_c);
    end
  endtask

  task automatic test_basic;
    logic [1:0] edat, ecap;
    @(posedge clk); #1 v_a = 1'b1; d_a = 4'b1001;
    @(posedge clk); #1 v_a = 1'b0; d_a = 4'b1111;  // changes after acceptance are ignored
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      edat = (n <= 3) ? 2'b01 : 2'b10;
      ecap = (n == 2) ? 2'b01 : (n == 5) ? 2'b10 : 2'b00;
      checks++;
      if ({dat_a, cap_a, busy_a, done_a, rdy_a} !== {edat, ecap, n <= 6, n == 7, n == 7}) begin
        errors++; $display("FAIL basic_cycle%0d got dat=%b cap=%b busy=%b done=%b rdy=%b want %b %b %b %b %b",
                           n, dat_a, cap_a, busy_a, done_a, rdy_a, edat, ecap, n <= 6, n == 7, n == 7);
      end
    end
    checks++;
    if (lat_a !== 4'b1001) begin errors++; $display("FAIL basic_array got=%b want=1001", lat_a); end
  endtask

  task automatic test_timing;
    logic [1:0] edat, ecap;
    int busy_cnt, c, ph;
    busy_cnt = 0;
    @(posedge clk); #1 v_b = 1'b1; d_b = 4'b0110;
    @(posedge clk); #1 v_b = 1'b0; d_b = 4'b0000;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (busy_b) busy_cnt++;
      c  = (n <= 14) ? (n - 1) / 7 : 1;
      ph = (n - 1) % 7;
      edat = col_bits(12'(4'b0110), c, 2, 2)[1:0];
      ecap = (n <= 14 && ph >= 2 && ph <= 4) ? 2'(1 << c) : 2'b00;
      checks++;
      if ({dat_b, cap_b, busy_b, done_b} !== {edat, ecap, n <= 14, n == 15}) begin
        errors++; $display("FAIL timing_cycle%0d got dat=%b cap=%b busy=%b done=%b want %b %b %b %b",
                           n, dat_b, cap_b, busy_b, done_b, edat, ecap, n <= 14, n == 15);
      end
    end
    checks++;
    if (busy_cnt != 14) begin errors++; $display("FAIL timing_busy_len got=%0d want=14", busy_cnt); end
    checks++;
    if (lat_b !== 4'b0110) begin errors++; $display("FAIL timing_array got=%b want=0110", lat_b); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(posedge clk); #1 v_a = 1'b1; d_a = 4'b1111;
    @(posedge clk); #1 d_a = 4'b0000;  // in_valid stays high
    wait_done_a(20, ok);
    checks++;
    if (!ok || rdy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_first got done=%b rdy=%b want 1 1", ok, rdy_a);
    end
    checks++;
    if (lat_a !== 4'b1111) begin errors++; $display("FAIL b2b_array1 got=%b want=1111", lat_a); end
    @(posedge clk); #1 v_a = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_second_accept busy=%b want=1", busy_a); end
    wait_done_a(20, ok);
    checks++;
    if (!ok || lat_a !== 4'b0000) begin
      errors++; $display("FAIL b2b_array2 done=%b got=%b want=0000", ok, lat_a);
    end
  endtask

  task automatic test_ignore_busy;
    bit ok;
    @(posedge clk); #1 v_a = 1'b1; d_a = 4'b0011;
    @(posedge clk); #1 v_a = 1'b0;
    @(posedge clk); #1 v_a = 1'b1; d_a = 4'b0101;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL ignore_ready got rdy=%b busy=%b want 0 1", rdy_a, busy_a);
    end
    @(posedge clk); #1 v_a = 1'b0; d_a = 4'b0000;
    wait_done_a(20, ok);
    checks++;
    if (!ok || lat_a !== 4'b0011) begin
      errors++; $display("FAIL ignore_array done=%b got=%b want=0011", ok, lat_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL ignore_restart busy=%b want=0", busy_a); end
  endtask

  task automatic test_random_3x4;
    bit ok;
    logic [11:0] w;
    for (int k = 0; k < 2; k++) begin
      w = 12'($urandom);
      @(posedge clk); #1 v_c = 1'b1; d_c = w;
      @(posedge clk); #1 v_c = 1'b0; d_c = ~w;
      wait_done_c(40, ok);
      checks++;
      if (!ok || lat_c !== w) begin
        errors++; $display("FAIL rand3x4_%0d done=%b got=%h want=%h", k, ok, lat_c, w);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 v_a = 1'b1; d_a = 4'b1010;
    @(posedge clk); #1 v_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cap_a !== 2'b10) begin errors++; $display("FAIL rstmid_capture cap=%b want=10", cap_a); end
    #1 rst = 1'b1;
    q_a.delete();
    @(negedge clk);
    checks++;
    if ({cap_a, dat_a, busy_a, rdy_a, done_a} !== 7'b0) begin
      errors++; $display("FAIL rstmid_clear got cap=%b dat=%b busy=%b rdy=%b done=%b want all 0",
                         cap_a, dat_a, busy_a, rdy_a, done_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got rdy=%b done=%b want 0 0", rdy_a, done_a);
    end
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready got rdy=%b done=%b want 1 0", rdy_a, done_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_back_to_back();
    test_ignore_busy();
    test_random_3x4();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
